lsu2ahb: RTL and testbench

Single-outstanding AHB master bridge between the riscv32 core's load/store stage and the RAM AHB slave. It accepts one CPU memory request at a time, checks its address window and alignment, and packs the access type into the upper AHB address bits. It drives the slave's hsel/haddr/hwrite/hwdata handshake and returns one response pulse per request, either read data or an error.

---
 rtl/ahb_pkg.sv | 42 ++++
 rtl/lsu_req_check.sv | 49 ++++
 rtl/lsu2ahb.sv | 136 +++++++++++++
 tb/tb_lsu2ahb.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ahb_pkg
// Brief   : Shared LSU/RAM AHB definitions: rwtyp codes, bridge states and
//           packed-haddr field positions decoded by both ends of the bus.
// Rev     : 1.0  initial release
// ============================================================================
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

package ahb_pkg;

    localparam int AHB_AW = `AHB_ADDR_WIDTH;
    localparam int AHB_DW = `AHB_DATA_WIDTH;

    // RISC-V funct3 access types; stores reuse the low three load encodings.
    localparam logic [2:0] RWTYP_LB  = 3'b000;
    localparam logic [2:0] RWTYP_LH  = 3'b001;
    localparam logic [2:0] RWTYP_LW  = 3'b010;
    localparam logic [2:0] RWTYP_LBU = 3'b100;
    localparam logic [2:0] RWTYP_LHU = 3'b101;
    localparam logic [2:0] RWTYP_SB  = 3'b000;
    localparam logic [2:0] RWTYP_SH  = 3'b001;
    localparam logic [2:0] RWTYP_SW  = 3'b010;

    localparam int HADDR_TYPE_MSB = 29;
    localparam int HADDR_TYPE_LSB = 27;
    localparam int HADDR_OFS_MSB  = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu2ahb_state_t;

endpackage

`default_nettype wire

// File: rtl/lsu_req_check.sv
`default_nettype none
// ============================================================================
// Module  : lsu_req_check
// Brief   : Combinational window/alignment/type check and haddr packing.
// Rev     : 1.0  initial release
// ============================================================================
module lsu_req_check
    import ahb_pkg::*;
#(
    parameter logic [15:0] RAM_BASE_HI = 16'h0000
) (
    input  logic              write,
    input  logic [AHB_AW-1:0] addr,
    input  logic [2:0]        rwtyp,
    output logic              ok,
    output logic [AHB_AW-1:0] haddr
);

    logic type_ok;
    logic align_ok;

    always_comb begin
        type_ok  = 1'b0;
        align_ok = 1'b1;
        if (write) begin
            case (rwtyp)
                RWTYP_SB: type_ok = 1'b1;
                RWTYP_SH: begin type_ok = 1'b1; align_ok = ~addr[0];              end
                RWTYP_SW: begin type_ok = 1'b1; align_ok = (addr[1:0] == 2'b00); end
                default:  type_ok = 1'b0;
            endcase
        end else begin
            case (rwtyp)
                RWTYP_LB, RWTYP_LBU: type_ok = 1'b1;
                RWTYP_LH, RWTYP_LHU: begin type_ok = 1'b1; align_ok = ~addr[0]; end
                RWTYP_LW: begin type_ok = 1'b1; align_ok = (addr[1:0] == 2'b00); end
                default:  type_ok = 1'b0;
            endcase
        end
        ok = type_ok & align_ok & (addr[AHB_AW-1:16] == RAM_BASE_HI);

        haddr = '0;
        haddr[HADDR_TYPE_MSB:HADDR_TYPE_LSB] = rwtyp;
        haddr[HADDR_OFS_MSB:0]               = addr[HADDR_OFS_MSB:0];
    end

endmodule

`default_nettype wire

// File: rtl/lsu2ahb.sv
`default_nettype none
// ============================================================================
// Module  : lsu2ahb
// Brief   : Single-outstanding bridge from the LSU request port to the RAM AHB.
// Rev     : 1.0  initial release
// ============================================================================
module lsu2ahb
    import ahb_pkg::*;
#(
    parameter logic [15:0] RAM_BASE_HI = 16'h0000,
    parameter int          TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [AHB_AW-1:0] req_addr,
    input  logic [AHB_DW-1:0] req_wdata,
    input  logic [2:0]        req_rwtyp,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [AHB_DW-1:0] resp_rdata,
    output logic              hsel,
    output logic              hwrite,
    output logic [AHB_AW-1:0] haddr,
    output logic [AHB_DW-1:0] hwdata,
    input  logic              hready,
    input  logic              hresp,
    input  logic [AHB_DW-1:0] hrdata
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    lsu2ahb_state_t    state, next_state;
    logic [7:0]        cnt, cnt_d;
    logic              chk_ok;
    logic [AHB_AW-1:0] chk_haddr;
    logic              bus_done;

    logic              hsel_d, hwrite_d, resp_valid_d, resp_err_d;
    logic [AHB_AW-1:0] haddr_d;
    logic [AHB_DW-1:0] hwdata_d, resp_rdata_d;

    lsu_req_check #(
        .RAM_BASE_HI (RAM_BASE_HI)
    ) u_check (
        .write (req_write),
        .addr  (req_addr),
        .rwtyp (req_rwtyp),
        .ok    (chk_ok),
        .haddr (chk_haddr)
    );

    assign req_ready = (state == ST_IDLE);
    // Writes finish on hresp only; the slave also pulses hready in its address phase.
    assign bus_done  = hwrite ? hresp : hready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hsel       <= 1'b0;
            hwrite     <= 1'b0;
            haddr      <= '0;
            hwdata     <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state      <= next_state;
            cnt        <= cnt_d;
            hsel       <= hsel_d;
            hwrite     <= hwrite_d;
            haddr      <= haddr_d;
            hwdata     <= hwdata_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
        end
    end

    always_comb begin
        next_state   = state;
        cnt_d        = cnt;
        hsel_d       = 1'b0;
        hwrite_d     = 1'b0;
        haddr_d      = '0;
        hwdata_d     = '0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;

        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (chk_ok) begin
                        next_state = ST_BUS;
                        cnt_d      = '0;
                        hsel_d     = 1'b1;
                        hwrite_d   = req_write;
                        haddr_d    = chk_haddr;
                        hwdata_d   = req_wdata;
                    end else begin
                        next_state   = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end
                end
            end
            ST_BUS: begin
                if (bus_done) begin
                    next_state   = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = hwrite ? '0 : hrdata;
                end else if (cnt == CNT_LAST) begin
                    next_state   = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d    = cnt + 8'd1;
                    hsel_d   = 1'b1;
                    hwrite_d = hwrite;
                    haddr_d  = haddr;
                    hwdata_d = hwdata;
                end
            end
            // RESP drops hsel for a cycle so the slave returns to idle.
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu2ahb.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu2ahb
// Brief   : Directed and randomized self-checking bench for lsu2ahb.
// Rev     : 1.0  initial release
// ============================================================================
module tb_lsu2ahb;

    localparam int          TIMEOUT = 16;
    localparam logic [15:0] BASE    = 16'h0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_rwtyp;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        hsel, hwrite;
    logic [31:0] haddr, hwdata;
    logic        hready, hresp;
    logic [31:0] hrdata;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [100:0] RESET_OUTS = {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};

    lsu2ahb #(.RAM_BASE_HI(BASE), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rwtyp  (req_rwtyp),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .hsel       (hsel),
        .hwrite     (hwrite),
        .haddr      (haddr),
        .hwdata     (hwdata),
        .hready     (hready),
        .hresp      (hresp),
        .hrdata     (hrdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference rules: legal sizes per access type, window and natural alignment.
    function automatic logic model_ok(input logic w, input logic [31:0] a, input logic [2:0] t);
        int size;
        case (t)
            3'd0:    size = 1;
            3'd1:    size = 2;
            3'd2:    size = 4;
            3'd4:    size = w ? 0 : 1;
            3'd5:    size = w ? 0 : 2;
            default: size = 0;
        endcase
        if (size == 0) return 1'b0;
        return (a[31:16] == BASE) && ((a % size) == 0);
    endfunction

    function automatic logic [31:0] model_haddr(input logic [31:0] a, input logic [2:0] t);
        return (32'(t) << 27) | (a & 32'h0000_FFFF);
    endfunction

    function automatic logic [100:0] outs();
        return {req_ready, resp_valid, resp_err, resp_rdata, hsel, hwrite, haddr, hwdata};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_rwtyp = 0;
        hready = 0; hresp = 0; hrdata = 0;
    endtask

    task automatic set_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_rwtyp = t;
    endtask

    task automatic test_reset();
        rstn = 0;
        idle_inputs();
        tick(); tick();
        vectors++;
        if (outs() !== RESET_OUTS) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", outs(), RESET_OUTS);
        end
        rstn = 1;
        tick();
    endtask

    task automatic test_read();
        set_req(0, 32'h0000_0010, 32'h0, 3'b010);
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL read_ready: got %b expected 1", req_ready); end
        tick(); req_valid = 0;
        vectors++;
        if ({hsel, hwrite, haddr} !== {1'b1, 1'b0, 32'h1000_0010}) begin
            miscompares++; $display("FAIL read_bus: got %h expected %h", {hsel, hwrite, haddr}, {1'b1, 1'b0, 32'h1000_0010});
        end
        tick();
        vectors++;
        if ({req_ready, hsel} !== 2'b01) begin miscompares++; $display("FAIL read_busy: got %b expected 01", {req_ready, hsel}); end
        tick(); hready = 1; hrdata = 32'hDEAD_BEEF;
        tick(); hready = 0; hrdata = 0;
        vectors++;
        if ({resp_valid, resp_err, resp_rdata, hsel} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0}) begin
            miscompares++; $display("FAIL read_resp: got %h expected %h", {resp_valid, resp_err, resp_rdata, hsel}, {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0});
        end
        tick();
        vectors++;
        if ({req_ready, resp_valid} !== 2'b10) begin miscompares++; $display("FAIL read_idle: got %b expected 10", {req_ready, resp_valid}); end
    endtask

    task automatic test_write();
        set_req(1, 32'h0000_0003, 32'h0000_00A5, 3'b000);
        tick(); req_valid = 0;
        vectors++;
        if ({hsel, hwrite, haddr, hwdata} !== {1'b1, 1'b1, 32'h3, 32'hA5}) begin
            miscompares++; $display("FAIL write_bus: got %h expected %h", {hsel, hwrite, haddr, hwdata}, {1'b1, 1'b1, 32'h3, 32'hA5});
        end
        tick(); hready = 1;
        tick(); hready = 0; hresp = 1;
        vectors++;
        if ({resp_valid, hsel, haddr, hwdata} !== {1'b0, 1'b1, 32'h3, 32'hA5}) begin
            miscompares++; $display("FAIL write_hready_ignored: got %h expected %h", {resp_valid, hsel, haddr, hwdata}, {1'b0, 1'b1, 32'h3, 32'hA5});
        end
        tick(); hresp = 0;
        vectors++;
        if ({resp_valid, resp_err, resp_rdata, hsel} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            miscompares++; $display("FAIL write_resp: got %h expected %h", {resp_valid, resp_err, resp_rdata, hsel}, {1'b1, 1'b0, 32'h0, 1'b0});
        end
        tick();
    endtask

    task automatic test_decode_err();
        logic [31:0] addrs [2];
        logic [2:0]  typs  [2];
        addrs[0] = 32'h0000_0001; typs[0] = 3'b001;
        addrs[1] = 32'h0001_0000; typs[1] = 3'b010;
        for (int i = 0; i < 2; i++) begin
            set_req(0, addrs[i], 32'h0, typs[i]);
            tick(); req_valid = 0;
            vectors++;
            if ({resp_valid, resp_err, resp_rdata, hsel} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
                miscompares++; $display("FAIL decode_err_%0d: got %h expected %h", i, {resp_valid, resp_err, resp_rdata, hsel}, {1'b1, 1'b1, 32'h0, 1'b0});
            end
            tick();
            vectors++;
            if ({req_ready, hsel, resp_valid} !== 3'b100) begin
                miscompares++; $display("FAIL decode_err_after_%0d: got %b expected 100", i, {req_ready, hsel, resp_valid});
            end
        end
    endtask

    task automatic test_timeout();
        set_req(0, 32'h0000_0020, 32'h0, 3'b010);
        tick(); req_valid = 0;
        for (int c = 1; c <= TIMEOUT; c++) begin
            vectors++;
            if ({hsel, resp_valid} !== 2'b10) begin
                miscompares++; $display("FAIL timeout_wait_c%0d: got %b expected 10", c, {hsel, resp_valid});
            end
            tick();
        end
        vectors++;
        if ({resp_valid, resp_err, resp_rdata, hsel} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            miscompares++; $display("FAIL timeout_resp: got %h expected %h", {resp_valid, resp_err, resp_rdata, hsel}, {1'b1, 1'b1, 32'h0, 1'b0});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        set_req(0, 32'h0000_0040, 32'h0, 3'b010);
        tick();
        set_req(0, 32'h0000_0044, 32'h0, 3'b010);
        vectors++;
        if ({hsel, haddr} !== {1'b1, 32'h1000_0040}) begin
            miscompares++; $display("FAIL b2b_first_bus: got %h expected %h", {hsel, haddr}, {1'b1, 32'h1000_0040});
        end
        tick();
        tick(); hready = 1; hrdata = 32'h1111_1111;
        tick(); hready = 0; hrdata = 0;
        vectors++;
        if ({hsel, req_ready, resp_valid, resp_rdata} !== {1'b0, 1'b0, 1'b1, 32'h1111_1111}) begin
            miscompares++; $display("FAIL b2b_first_resp: got %h expected %h", {hsel, req_ready, resp_valid, resp_rdata}, {1'b0, 1'b0, 1'b1, 32'h1111_1111});
        end
        tick();
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_accept_c5: got %b expected 1", req_ready); end
        tick(); req_valid = 0;
        vectors++;
        if ({hsel, haddr} !== {1'b1, 32'h1000_0044}) begin
            miscompares++; $display("FAIL b2b_second_bus: got %h expected %h", {hsel, haddr}, {1'b1, 32'h1000_0044});
        end
        tick();
        tick(); hready = 1; hrdata = 32'h2222_2222;
        tick(); hready = 0; hrdata = 0;
        vectors++;
        if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h2222_2222}) begin
            miscompares++; $display("FAIL b2b_second_resp: got %h expected %h", {resp_valid, resp_err, resp_rdata}, {1'b1, 1'b0, 32'h2222_2222});
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        set_req(0, 32'h0000_0080, 32'h0, 3'b010);
        tick(); req_valid = 0;
        tick();
        rstn = 0;
        #1;
        vectors++;
        if (outs() !== RESET_OUTS) begin
            miscompares++; $display("FAIL midreset_async: got %h expected %h", outs(), RESET_OUTS);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (outs() !== RESET_OUTS) begin
                miscompares++; $display("FAIL midreset_hold_%0d: got %h expected %h", i, outs(), RESET_OUTS);
            end
        end
        rstn = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({resp_valid, hsel, req_ready} !== 3'b001) begin
                miscompares++; $display("FAIL midreset_no_resp_%0d: got %b expected 001", i, {resp_valid, hsel, req_ready});
            end
        end
        set_req(0, 32'h0000_0100, 32'h0, 3'b010);
        tick(); req_valid = 0;
        tick();
        tick(); hready = 1; hrdata = 32'hCAFE_F00D;
        tick(); hready = 0; hrdata = 0;
        vectors++;
        if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
            miscompares++; $display("FAIL midreset_recover: got %h expected %h", {resp_valid, resp_err, resp_rdata}, {1'b1, 1'b0, 32'hCAFE_F00D});
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic        w, ok, to;
            logic [2:0]  t;
            logic [31:0] a, d, rd, ha;
            int          lat, done_c;
            w  = 1'($urandom % 2);
            t  = 3'($urandom % 8);
            a  = {(($urandom % 8) == 0) ? 16'($urandom) : BASE, 16'($urandom)};
            d  = $urandom;
            rd = $urandom;
            ok = model_ok(w, a, t);
            ha = model_haddr(a, t);
            set_req(w, a, d, t);
            vectors++;
            if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_ready: got %b expected 1", n, req_ready); end
            tick(); req_valid = 0;
            if (!ok) begin
                vectors++;
                if ({resp_valid, resp_err, resp_rdata, hsel} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
                    miscompares++; $display("FAIL rnd%0d_decode: got %h expected %h", n, {resp_valid, resp_err, resp_rdata, hsel}, {1'b1, 1'b1, 32'h0, 1'b0});
                end
                tick();
            end else begin
                lat    = $urandom_range(1, TIMEOUT + 2);
                to     = (lat > TIMEOUT);
                done_c = to ? TIMEOUT + 1 : lat + 1;
                for (int c = 1; c <= done_c; c++) begin
                    if (c < done_c) begin
                        vectors++;
                        if ({resp_valid, hsel, hwrite, haddr, hwdata} !== {1'b0, 1'b1, w, ha, d}) begin
                            miscompares++; $display("FAIL rnd%0d_bus_c%0d: got %h expected %h", n, c, {resp_valid, hsel, hwrite, haddr, hwdata}, {1'b0, 1'b1, w, ha, d});
                        end
                        hrdata = $urandom;
                        hresp  = 0;
                        hready = w ? 1'($urandom % 2) : 1'b0;
                        if (c == lat) begin
                            if (w) hresp = 1;
                            else begin hready = 1; hrdata = rd; end
                        end
                    end else begin
                        vectors++;
                        if ({resp_valid, resp_err, resp_rdata, hsel, hwrite, haddr, hwdata} !==
                            {1'b1, to, (w || to) ? 32'h0 : rd, 1'b0, 1'b0, 32'h0, 32'h0}) begin
                            miscompares++; $display("FAIL rnd%0d_resp: got %h expected %h", n,
                                {resp_valid, resp_err, resp_rdata, hsel, hwrite, haddr, hwdata},
                                {1'b1, to, (w || to) ? 32'h0 : rd, 1'b0, 1'b0, 32'h0, 32'h0});
                        end
                        hready = 0; hresp = 0; hrdata = 0;
                    end
                    tick();
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_decode_err();
        test_timeout();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
